// File: rtl/hilo_ctrl.sv
// HI/LO issue-and-writeback stage for the CPU54 multiply/divide path.
// Launches one MUL/DIV at a time, waits for ready (with a watchdog), and writes the result into HI/LO.
module hilo_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_rs,
  input  logic [31:0] op_rt,
  input  logic        mf_req,
  input  logic        mf_sel,
  output logic [31:0] mf_data,
  output logic        stall,
  output logic        mul_start,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_ready,
  input  logic [63:0] mul_z,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_ready,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign cnt_nxt = cnt + CNT_W'(1);
  assign busy    = (state != IDLE);
  assign stall   = busy & (op_valid | mf_req);
  // Read path is straight from the registers, so an mf in the accept cycle sees pre-op values.
  assign mf_data = mf_sel ? hi : lo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      div_a       <= '0;
      div_b       <= '0;
      mul_start   <= 1'b0;
      mul_signed  <= 1'b0;
      div_start   <= 1'b0;
      div_signed  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            case (op_code)
              OP_MULT, OP_MULTU: begin
                mul_a      <= op_rs;
                mul_b      <= op_rt;
                mul_signed <= (op_code == OP_MULT);
                mul_start  <= 1'b1;
                cnt        <= '0;
                state      <= MUL_WAIT;
              end
              OP_DIV, OP_DIVU: begin
                // Divide by zero is dropped here: no start, HI/LO keep their values.
                if (op_rt != 32'd0) begin
                  div_a      <= op_rs;
                  div_b      <= op_rt;
                  div_signed <= (op_code == OP_DIV);
                  div_start  <= 1'b1;
                  cnt        <= '0;
                  state      <= DIV_WAIT;
                end
              end
              OP_MTHI: hi <= op_rs;
              OP_MTLO: lo <= op_rs;
              default: ;
            endcase
          end
        end
        MUL_WAIT: begin
          if (mul_ready) begin
            hi    <= mul_z[63:32];
            lo    <= mul_z[31:0];
            state <= IDLE;
          end else if (cnt_nxt == CNT_W'(TIMEOUT)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        DIV_WAIT: begin
          if (div_ready) begin
            hi    <= div_r;
            lo    <= div_q;
            state <= IDLE;
          end else if (cnt_nxt == CNT_W'(TIMEOUT)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
